// File: rtl/data_sram_responder.sv
// Responder end of the EX-stage data SRAM interface: word memory with byte-lane
// writes, synchronous reads and optional wait states reported through stallreq.
module data_sram_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = 0,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        rdata_valid,
  output logic        stallreq,
  output logic        addr_err
);

  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] SPAN   = 33'(33'd1 << (ADDR_W + 2));
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [31:0]        mem_q [DEPTH];

  logic [31:0]        off_s;
  logic [ADDR_W-1:0]  idx_s;
  logic               in_range_s;
  logic               is_write_s;
  logic               commit_s;
  logic               stall_s;
  logic               mem_we_s;

  // Address decode: a base below BASE_ADDR wraps to a huge offset and lands out of range.
  always_comb begin
    off_s      = data_sram_addr - BASE_ADDR;
    idx_s      = off_s[ADDR_W+1:2];
    in_range_s = ({1'b0, off_s} < SPAN);
    is_write_s = (data_sram_wen != 4'b0000);
  end

  // Wait-state sequencing: abort beats commit, commit beats counting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_s = 1'b0;
    stall_s  = 1'b0;
    if (LATENCY == 0) begin
      commit_s = data_sram_en;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (data_sram_en) begin
            stall_s = 1'b1;
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!data_sram_en) begin
            state_d = ST_IDLE;
          end else if (cnt_q == {CNT_W{1'b0}}) begin
            commit_s = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            stall_s = 1'b1;
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Next values of the registered response outputs.
  always_comb begin
    rdata_d = rdata_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (commit_s) begin
      err_d = !in_range_s;
      if (!is_write_s) begin
        valid_d = 1'b1;
        rdata_d = in_range_s ? mem_q[idx_s] : 32'h0000_0000;
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      rdata_q <= 32'h0000_0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // The array is deliberately not reset; writes are suppressed while reset is held.
  assign mem_we_s = commit_s && is_write_s && in_range_s && rst;

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) begin
          mem_q[idx_s][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign rdata_valid     = valid_q;
  assign addr_err        = err_q;
  assign stallreq        = stall_s && rst;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: four instances (two single-cycle
// geometries, LATENCY=3, LATENCY=2) sharing one request bus.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata [4];
  logic        valid [4];
  logic        stall [4];
  logic        err   [4];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(10), .LATENCY(0), .BASE_ADDR(32'h0000_0000)) u_d0 (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_rdata(rdata[0]), .rdata_valid(valid[0]),
    .stallreq(stall[0]), .addr_err(err[0]));
  data_sram_responder #(.ADDR_W(4), .LATENCY(0), .BASE_ADDR(32'h0000_1000)) u_d1 (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_rdata(rdata[1]), .rdata_valid(valid[1]),
    .stallreq(stall[1]), .addr_err(err[1]));
  data_sram_responder #(.ADDR_W(10), .LATENCY(3), .BASE_ADDR(32'h0000_0000)) u_d2 (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_rdata(rdata[2]), .rdata_valid(valid[2]),
    .stallreq(stall[2]), .addr_err(err[2]));
  data_sram_responder #(.ADDR_W(10), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_d3 (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_rdata(rdata[3]), .rdata_valid(valid[3]),
    .stallreq(stall[3]), .addr_err(err[3]));

  typedef struct {
    int          dut;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_outs(input string tag, input int k, input logic [31:0] r,
                          input logic v, input logic e);
    chk({tag, "_rdata"}, rdata[k], r);
    chk({tag, "_valid"}, {31'd0, valid[k]}, {31'd0, v});
    chk({tag, "_err"},   {31'd0, err[k]},   {31'd0, e});
  endtask

  // Issue one request on the wait-state instance k, count stall cycles, return
  // at the sample point just after the commit edge with en dropped.
  task automatic req(input int k, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d, input int lat);
    int n;
    en = 1'b1; wen = w; addr = a; wdata = d;
    n = 0;
    #1;
    while (stall[k] && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("stall_cycles", 32'(n), 32'(lat));
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk_outs("reset", k, 32'h0, 1'b0, 1'b0);
      chk("reset_stall", {31'd0, stall[k]}, 32'd0);
    end
    rst = 1'b1;

    vecs[0]  = '{0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1]  = '{0, 1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[2]  = '{0, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[3]  = '{0, 1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[4]  = '{0, 1'b1, 4'h0, 32'h0000_0020, 32'h0,         32'h11BB_33DD, 1'b1, 1'b0};
    vecs[5]  = '{0, 1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'h11BB_33DD, 1'b0, 1'b0};
    vecs[6]  = '{0, 1'b1, 4'h0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[7]  = '{0, 1'b1, 4'hF, 32'h0000_0FFC, 32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[8]  = '{0, 1'b1, 4'h0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1, 1'b1};
    vecs[9]  = '{0, 1'b1, 4'h0, 32'h0000_0FFC, 32'h0,         32'h0BAD_F00D, 1'b1, 1'b0};
    vecs[10] = '{0, 1'b1, 4'h8, 32'h0000_0010, 32'h5500_0000, 32'h0BAD_F00D, 1'b0, 1'b0};
    vecs[11] = '{0, 1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'h55AD_BEEF, 1'b1, 1'b0};
    vecs[12] = '{1, 1'b1, 4'hF, 32'h0000_103C, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1'b0};
    vecs[13] = '{1, 1'b1, 4'h0, 32'h0000_103C, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[14] = '{1, 1'b1, 4'h0, 32'h0000_1040, 32'h0,         32'h0000_0000, 1'b1, 1'b1};
    vecs[15] = '{1, 1'b1, 4'hF, 32'h0000_0FFC, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1};
    vecs[16] = '{1, 1'b1, 4'h0, 32'h0000_103C, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[17] = '{1, 1'b1, 4'h0, 32'h0000_0FFC, 32'h0,         32'h0000_0000, 1'b1, 1'b1};

    for (int i = 0; i < 18; i++) begin
      en = vecs[i].en; wen = vecs[i].wen; addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_stall", i), {31'd0, stall[vecs[i].dut]}, 32'd0);
      @(posedge clk); #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].dut, vecs[i].exp_rdata,
               vecs[i].exp_valid, vecs[i].exp_err);
    end

    en = 1'b0;
    @(posedge clk); #1;

    // LATENCY=3: three stall cycles, commit on the fourth, valid on the fifth.
    req(2, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 3);
    chk("l3_write_valid", {31'd0, valid[2]}, 32'd0);
    req(2, 4'h0, 32'h0000_0010, 32'h0, 3);
    chk_outs("l3_read", 2, 32'hDEAD_BEEF, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("l3_valid_drop", {31'd0, valid[2]}, 32'd0);

    // LATENCY=2: abort by dropping en inside WAIT.
    req(3, 4'hF, 32'h0000_0040, 32'h600D_CAFE, 2);
    en = 1'b1; wen = 4'h0; addr = 32'h0000_0040;
    #1;
    chk("abort_stall_idle", {31'd0, stall[3]}, 32'd1);
    @(posedge clk); #1;
    chk("abort_stall_wait", {31'd0, stall[3]}, 32'd1);
    en = 1'b0;
    #1;
    chk("abort_stall_drop", {31'd0, stall[3]}, 32'd0);
    @(posedge clk); #1;
    chk("abort_valid", {31'd0, valid[3]}, 32'd0);
    chk("abort_err", {31'd0, err[3]}, 32'd0);
    req(3, 4'h0, 32'h0000_0040, 32'h0, 2);
    chk_outs("post_abort_read", 3, 32'h600D_CAFE, 1'b1, 1'b0);

    // Reset in the middle of WAIT, then confirm memory survived it.
    req(3, 4'hF, 32'h0000_0040, 32'h0F0F_0F0F, 2);
    en = 1'b1; wen = 4'h0; addr = 32'h0000_0040;
    @(posedge clk); #1;
    chk("pre_rst_stall", {31'd0, stall[3]}, 32'd1);
    rst = 1'b0;
    #1;
    chk_outs("mid_rst", 3, 32'h0, 1'b0, 1'b0);
    chk("mid_rst_stall", {31'd0, stall[3]}, 32'd0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    req(3, 4'h0, 32'h0000_0040, 32'h0, 2);
    chk_outs("post_rst_read", 3, 32'h0F0F_0F0F, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
